// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and index-width helper for the weighted round-robin arbiter
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
  localparam int ARB_N_MAX = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker, first requester at or after ptr (mod N)
module rr_pick import arb_pkg::*; #(
  parameter int N = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);
  logic [2*N-1:0] dbl;
  int sum;
  assign dbl = {req, req} >> ptr;
  assign found = |req;
  always_comb begin
    sum = 0;
    for (int k = N - 1; k >= 0; k--)
      sum = dbl[k] ? int'(ptr) + k : sum;
    idx = IW'(sum >= N ? sum - N : sum);
  end
endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter; ARB_LOCK_EN adds a lock port that lets the owner overrun its budget
module wrr_arbiter import arb_pkg::*; #(
  parameter int N = 4,
  parameter int WW = 4,
  localparam int IW = idx_w(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            ready,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);
  arb_state_e state;
  logic [IW-1:0] ptr, owner, nxt, pptr, win;
  logic [WW-1:0] credit, load;
  logic [WW-1:0] wf [N];
  logic found, beat, last, rel, take;
  always_comb
    for (int i = 0; i < N; i++)
      wf[i] = weight[i*WW +: WW];
  assign nxt = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
  // After a release the search restarts just past the old owner, so it ranks last
  assign pptr = (state == ARB_GRANT) ? nxt : ptr;
  assign load = (wf[win] == '0) ? WW'(1) : wf[win];
  assign beat = ready && req[owner];
`ifdef ARB_LOCK_EN
  assign last = (credit == WW'(1)) && !lock[owner];
`else
  assign last = credit == WW'(1);
`endif
  assign rel = !req[owner] || (beat && last);
  assign take = (state == ARB_IDLE) ? found : rel;

  rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (pptr),
    .idx  (win),
    .found(found)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      owner    <= '0;
      credit   <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else if (take) begin
      ptr      <= pptr;
      state    <= found ? ARB_GRANT : ARB_IDLE;
      grant    <= found ? N'(1) << win : '0;
      grant_id <= found ? win : '0;
      busy     <= found;
      owner    <= found ? win : owner;
      credit   <= found ? load : credit;
    end else if (state == ARB_GRANT && beat && credit != WW'(1)) begin
      credit <= credit - WW'(1);
    end
  end
endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: table-driven scoreboard bench for wrr_arbiter (N=4, WW=4)
module tb_wrr_arbiter;
  logic clk, reset, ready;
  logic [3:0] req, grant;
  logic [15:0] weight;
  logic [1:0] grant_id;
  logic busy;
`ifdef ARB_LOCK_EN
  logic [3:0] lock;
`endif
  typedef struct {logic [3:0] req; logic ready; logic [3:0] g;} vec_t;
  typedef struct {logic [3:0] g; string name;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  wrr_arbiter #(.N(4), .WW(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .weight  (weight),
    .ready   (ready),
`ifdef ARB_LOCK_EN
    .lock    (lock),
`endif
    .grant   (grant),
    .grant_id(grant_id),
    .busy    (busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] idof(input logic [3:0] g);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    if (grant !== e.g || grant_id !== idof(e.g) || busy !== |e.g) begin
      errors++;
      $display("FAIL %s: grant=%b id=%0d busy=%b, expected grant=%b id=%0d busy=%b",
               e.name, grant, grant_id, busy, e.g, idof(e.g), |e.g);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    req = v.req;
    ready = v.ready;
    sb.push_back('{v.g, name});
    @(posedge clk);
    #1 check();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0;
    ready = 1'b0;
    sb.push_back('{4'b0000, "reset"});
    @(posedge clk);
    #1 check();
    reset = 1'b1;
  endtask

  vec_t t1[4], t2[9], t3[8], t4[12];

  initial begin
    reset = 1'b0;
    req = '0;
    ready = 1'b0;
    weight = 16'h1111;
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
    t1 = '{'{4'b0000, 1'b1, 4'b0000}, '{4'b0100, 1'b0, 4'b0100},
           '{4'b0100, 1'b0, 4'b0100}, '{4'b0000, 1'b0, 4'b0000}};
    t2 = '{'{4'b1111, 1'b1, 4'b0001}, '{4'b1111, 1'b1, 4'b0001}, '{4'b1111, 1'b1, 4'b0010},
           '{4'b1111, 1'b1, 4'b0010}, '{4'b1111, 1'b1, 4'b0100}, '{4'b1111, 1'b1, 4'b0100},
           '{4'b1111, 1'b1, 4'b1000}, '{4'b1111, 1'b1, 4'b1000}, '{4'b1111, 1'b1, 4'b0001}};
    t3 = '{'{4'b0011, 1'b1, 4'b0001}, '{4'b0011, 1'b1, 4'b0001}, '{4'b0011, 1'b1, 4'b0001},
           '{4'b0011, 1'b1, 4'b0010}, '{4'b0011, 1'b1, 4'b0001}, '{4'b0011, 1'b1, 4'b0001},
           '{4'b0011, 1'b1, 4'b0001}, '{4'b0011, 1'b1, 4'b0010}};
    t4 = '{'{4'b1001, 1'b1, 4'b0001}, '{4'b1001, 1'b1, 4'b0001}, '{4'b1001, 1'b1, 4'b0001},
           '{4'b1001, 1'b0, 4'b0001}, '{4'b1000, 1'b1, 4'b1000}, '{4'b1000, 1'b1, 4'b1000},
           '{4'b1000, 1'b0, 4'b1000}, '{4'b1000, 1'b0, 4'b1000}, '{4'b1000, 1'b1, 4'b1000},
           '{4'b1000, 1'b1, 4'b1000}, '{4'b1000, 1'b0, 4'b1000}, '{4'b0000, 1'b0, 4'b0000}};
    #1;
    do_reset();
    for (int i = 0; i < 4; i++) step(t1[i], $sformatf("idle_then_req2[%0d]", i));

    do_reset();
    weight = 16'h2222;
    for (int i = 0; i < 9; i++) step(t2[i], $sformatf("rr_w2[%0d]", i));

    do_reset();
    weight = 16'h3303;
    for (int i = 0; i < 8; i++) step(t3[i], $sformatf("w0_alternate[%0d]", i));

    do_reset();
    weight = 16'h2114;
    for (int i = 0; i < 12; i++) step(t4[i], $sformatf("withdraw_ready_gaps[%0d]", i));

`ifdef ARB_LOCK_EN
    do_reset();
    weight = 16'h1111;
    step('{4'b0100, 1'b0, 4'b0100}, "lock_grant");
    lock = 4'b0100;
    for (int i = 0; i < 5; i++) step('{4'b0101, 1'b1, 4'b0100}, $sformatf("lock_hold[%0d]", i));
    lock = 4'b0000;
    step('{4'b0101, 1'b1, 4'b0001}, "lock_release");
`endif

    // Asynchronous reset mid-grant, then arbitration restarts from index 0
    do_reset();
    weight = 16'h1111;
    step('{4'b0010, 1'b0, 4'b0010}, "pre_async");
    #2 reset = 1'b0;
    sb.push_back('{4'b0000, "async_reset"});
    #1 check();
    @(posedge clk);
    #1 reset = 1'b1;
    step('{4'b1010, 1'b0, 4'b0010}, "post_reset_ptr0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Weighted round-robin arbiter that shares one beat-based resource (bus, memory port, FIFO write side) among N requesters. A winner keeps the grant for up to its programmed weight in accepted beats, then the grant rotates to the next requester in round-robin order. The block sits between the requester ports and the resource handshake, and drives the resource's select mux.

## Interface
- N, 4, number of requesters (2..16, need not be a power of two)
- WW, 4, width of each per-requester weight field
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req  input  N  request per requester; held high while it has beats to send
- weight  input  N*WW  beat budget per requester, field i at [i*WW +: WW]; sampled when a grant is issued
- ready  input  1  resource accepts the granted beat this cycle
- lock  input  N  only present with ARB_LOCK_EN; owner requests to keep the grant past its budget
- grant  output  N  registered one-hot grant (all-zero when idle)
- grant_id  output  $clog2(N)  index of the current owner; 0 when idle
- busy  output  1  high while in GRANT state

## Operation
- FSM has two states: IDLE and GRANT.
- Internal state:
  - rotating pointer ptr, $clog2(N) bits, wraps N-1 -> 0;
  - owner index;
  - credit counter, WW bits.
- Winner selection: first i with req[i]=1, searching ptr, ptr+1, ... mod N.
- IDLE:
  - if |req, register the winner into grant/grant_id;
  - load credit = weight[winner], with 0 treated as 1;
  - go to GRANT.
- GRANT:
  - a beat is one cycle with ready && req[owner];
  - each beat decrements credit.
- Release occurs on either of:
  - (a) a beat with credit==1 (budget exhausted);
  - (b) req[owner]==0 (requester withdrew; no beat counted).
- On release:
  - ptr <= owner+1 mod N;
  - if any req is high, pick a new winner from the new ptr and load its weight in the same edge (no idle gap);
  - otherwise clear grant and return to IDLE.
- On back-to-back release, the previous owner has lowest priority but can be re-granted if it is the sole requester.
- Outputs when not in GRANT: grant=0, grant_id=0, busy=0.
- ready while idle is ignored.
- Weight changes take effect only at the next grant issue.

## Timing
- Reset values: grant=0, grant_id=0, busy=0, ptr=0, credit=0, state IDLE.
  - Reset mid-grant drops the grant asynchronously.
  - The first post-reset arbitration starts from index 0.
- Latency:
  - req rising in IDLE -> grant high on the next clk edge (1 cycle);
  - final beat -> next owner's grant on the same edge that removes the old grant.
- Grant is stable between releases; at most one bit set at any time.
- The owner sees grant, drives its beat, and the beat completes in the cycle where ready=1.
- Throughput: with continuous ready, requester i gets exactly max(weight[i],1) consecutive beats per turn.

## Configuration
- ARB_LOCK_EN defined:
  - the lock port exists;
  - when credit==1 and lock[owner]==1, a beat does not release and credit holds at 1;
  - release occurs on the first beat with lock[owner]==0, or on req[owner]==0.
- ARB_LOCK_EN undefined:
  - no lock port;
  - release strictly by budget or withdrawal as above.

## Structure
- Package arb_pkg holds:
  - the state enum typedef arb_state_e {ARB_IDLE, ARB_GRANT};
  - a localparam helper for the index width.
- One sub-module: rr_pick, a purely combinational rotating-priority picker.
  - Inputs: req[N], ptr.
  - Outputs: winner index and a found flag.
  - Instantiated once; the FSM, counters and registers live in wrr_arbiter.

## Test plan
- Reset, then req=4'b0000 -> grant stays 0, busy=0; assert req=4'b0100 -> grant=4'b0100 and grant_id=2 one cycle later.
- All weights=2, req=4'b1111, ready=1 continuous -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001, with no gap cycles.
- weight=0 for requester 1, weight=3 for the others, req=4'b0011 -> one beat for req 1 and three beats for req 0, alternating.
- Owner 0 with weight=4: drop req[0] after 2 beats while req[3]=1 -> grant moves to 1000 next edge and ptr becomes 1; ready low cycles do not decrement credit.
- With ARB_LOCK_EN, weight=1, lock[2]=1 for 5 beats -> grant=0100 for 5 beats, released on the first beat with lock low.
- Assert reset low mid-grant -> grant=0 immediately (asynchronous); after release, req=4'b1010 -> grant=0010 first, since ptr restarts at 0.
